fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC, drives the instruction-memory request, and fills the IF/ID pipeline register.
- Presents opcode and funct from IF/ID to the control decoder.
- Accepts control-transfer redirects (branch/jump/jal/jr targets resolved in ID) and load-use stalls from the hazard unit.

---
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// fills the IF/ID register, honouring redirects, load-use stalls and memory wait states.
module fetch_unit #(
  parameter int              PC_W     = 18,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_WORD = 32'h0000_0000,
  parameter int              MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc4,
  output logic            if_id_valid,
  output logic [5:0]      opcode,
  output logic [5:0]      funct,
  output logic            fetch_err
);

  typedef enum logic {BOOT, FETCH} state_t;

  localparam logic [7:0] MAX_WAIT_C = MAX_WAIT[7:0];

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic [7:0]      wait_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    sat_inc = (cnt >= MAX_WAIT_C) ? MAX_WAIT_C : cnt + 8'd1;
  endfunction

  // Wraps modulo 2^PC_W; this wrapped value is also the jal link value.
  assign pc_plus4  = pc + PC_W'(4);
  assign imem_addr = pc;
  assign opcode    = if_id_instr[31:26];
  assign funct     = if_id_instr[5:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      imem_req    <= 1'b0;
      pc          <= RESET_PC;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          imem_req <= 1'b1;
          if (redirect) begin
            pc          <= {redirect_pc[PC_W-1:2], 2'b00};
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
            wait_cnt    <= '0;
          end else if (stall) begin
            // Returned word is dropped; the same address is re-presented.
          end else if (imem_ready) begin
            pc          <= pc_plus4;
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            wait_cnt    <= '0;
          end else begin
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
            wait_cnt    <= sat_inc(wait_cnt);
            if (sat_inc(wait_cnt) >= MAX_WAIT_C) fetch_err <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, wait states, stall, redirect, timeout,
// PC wrap and asynchronous reset, against hand-computed expectations.
module tb_fetch_unit;

  localparam int PC_W = 18;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic            stall;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     if_id_instr;
  logic [PC_W-1:0] if_id_pc4;
  logic            if_id_valid;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic            fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .opcode(opcode), .funct(funct), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Memory returns an address-tagged word: opcode 0x23, address in the low bits.
  assign imem_rdata = {6'h23, 8'h00, imem_addr};

  function automatic logic [31:0] w(input logic [PC_W-1:0] a);
    w = {6'h23, 8'h00, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr,
                          input logic [PC_W-1:0] pc4, input logic vld,
                          input logic [PC_W-1:0] addr);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc4"},   32'(if_id_pc4), 32'(pc4));
    check({tag, ".valid"}, 32'(if_id_valid), 32'(vld));
    check({tag, ".addr"},  32'(imem_addr), 32'(addr));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, ".req"},   32'(imem_req), 32'd0);
    check({tag, ".addr"},  32'(imem_addr), 32'd0);
    check({tag, ".instr"}, if_id_instr, 32'd0);
    check({tag, ".pc4"},   32'(if_id_pc4), 32'd0);
    check({tag, ".valid"}, 32'(if_id_valid), 32'd0);
    check({tag, ".err"},   32'(fetch_err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) step();
    chk_reset("rst");
    rst_n = 1'b1;

    // Boot and streaming fetch
    step();
    check("boot.req", 32'(imem_req), 32'd1);
    chk_ifid("boot", 32'd0, 18'h0, 1'b0, 18'h0);
    step(); chk_ifid("s0", w(18'h0), 18'h4, 1'b1, 18'h4);
    check("s0.opcode", 32'(opcode), 32'h23);
    step(); chk_ifid("s4", w(18'h4), 18'h8, 1'b1, 18'h8);
    check("s4.funct", 32'(funct), 32'h04);

    // Three wait states at 0x8
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid("wait", 32'd0, 18'h8, 1'b0, 18'h8);
      check("wait.opcode", 32'(opcode), 32'd0);
    end
    imem_ready = 1'b1;
    step(); chk_ifid("w8", w(18'h8), 18'hC, 1'b1, 18'hC);
    check("w8.err", 32'(fetch_err), 32'd0);

    // Stall while fetching 0x10
    step(); chk_ifid("sC", w(18'hC), 18'h10, 1'b1, 18'h10);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_ifid("stall", w(18'hC), 18'h10, 1'b1, 18'h10);
    end
    stall = 1'b0;
    step(); chk_ifid("s10", w(18'h10), 18'h14, 1'b1, 18'h14);

    // Redirect overrides stall; low bits of target ignored
    redirect = 1'b1; redirect_pc = 18'h43; stall = 1'b1;
    step(); chk_ifid("redir", 32'd0, 18'h14, 1'b0, 18'h40);
    redirect = 1'b0; stall = 1'b0;
    step(); chk_ifid("s40", w(18'h40), 18'h44, 1'b1, 18'h44);

    // Memory timeout: 16 consecutive not-ready edges
    imem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) check("tmo15.err", 32'(fetch_err), 32'd0);
    end
    check("tmo16.err", 32'(fetch_err), 32'd1);
    check("tmo16.addr", 32'(imem_addr), 32'h44);
    imem_ready = 1'b1;
    step(); chk_ifid("s44", w(18'h44), 18'h48, 1'b1, 18'h48);
    check("s44.err", 32'(fetch_err), 32'd1);

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 18'h3FFFC;
    step(); chk_ifid("rtop", 32'd0, 18'h48, 1'b0, 18'h3FFFC);
    redirect = 1'b0;
    step(); chk_ifid("wrap", w(18'h3FFFC), 18'h0, 1'b1, 18'h0);

    // Asynchronous reset in the middle of a wait
    imem_ready = 1'b0;
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1 chk_reset("arst");
    step();
    rst_n = 1'b1;
    imem_ready = 1'b1;
    step();
    check("reboot.req", 32'(imem_req), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
